// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link (generator and checker).
// Holds the even/odd parity sense constants and the receive FSM state
// encoding so both ends of the link agree on them.
package parity_pkg;

  // Parity sense: EVEN means the total count of ones, parity bit included,
  // is even; ODD means that count is odd.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial receive link bundle.
//   x       : serial data/parity bit
//   x_valid : qualifies x and sof
//   sof     : start of frame, marks x as data bit 0
// Handshake: a bit transfers on every posedge where x_valid=1. There is no
// ready signal because the receiver always accepts. x_valid=0 is a stall.
// sof has no meaning unless x_valid=1 in the same cycle.
interface serial_parity_checker_if;
  logic x;
  logic x_valid;
  logic sof;

  modport master (output x, output x_valid, output sof);
  modport slave  (input  x, input  x_valid, input  sof);
endinterface

// File: rtl/parity_accum.sv
// Running XOR accumulator. The transmit-side generator uses the same block.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the accumulator to 0
//   load     : restart the accumulator with d (this takes priority over clr/en)
//   en       : fold d into the accumulator (par ^= d)
//   d        : input bit
//   par      : current accumulated parity
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic d,
  output logic par
);

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= d;
    end else if (clr) begin
      par <= 1'b0;
    end else if (en) begin
      par <= par ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker. It deserialises frames made of DATA_BITS data bits,
// sent LSB first, followed by one parity bit. It presents each completed word
// together with a parity error flag, and it keeps a saturating count of bad
// frames.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   sin        : serial link (x, x_valid, sof), slave side
//   data_out   : last completed word, held until the next done
//   done       : one-cycle pulse when data_out/err update
//   err        : parity error of the frame signalled by done, held with it
//   abort      : one-cycle pulse when a new sof discards a frame in flight
//   busy       : state is DATA or PARITY
//   err_count  : number of bad frames, saturating at all-ones
//   dbg_state  : current FSM state
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_parity_checker_if.slave   sin,
  output logic [DATA_BITS-1:0]     data_out,
  output logic                     done,
  output logic                     err,
  output logic                     abort,
  output logic                     busy,
  output logic [CNT_W-1:0]         err_count,
  output state_t                   dbg_state
);

  localparam int   IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 run_par;

  // One-hot decoded actions for this cycle.
  logic ld_first;   // sof accepted: x becomes data bit 0 of a new frame
  logic shift_en;   // ordinary data bit stored at idx
  logic par_check;  // parity bit sampled: the frame completes next cycle
  logic abort_nxt;  // a frame in flight is being replaced by a new sof
  logic mismatch;

  assign mismatch  = run_par ^ sin.x ^ PAR_SENSE;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    shift_en  = 1'b0;
    par_check = 1'b0;
    abort_nxt = 1'b0;

    if (sin.x_valid) begin
      if (sin.sof) begin
        // sof restarts the frame from any state. It counts as an abort only
        // when a frame was already in progress.
        ld_first  = 1'b1;
        abort_nxt = (state != IDLE);
        state_nxt = DATA;
      end else begin
        unique case (state)
          IDLE: begin
            state_nxt = IDLE;
          end
          DATA: begin
            shift_en = 1'b1;
            if (idx == LAST_IDX) begin
              state_nxt = PARITY;
            end
          end
          PARITY: begin
            par_check = 1'b1;
            state_nxt = IDLE;
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  parity_accum u_par (
    .clk  (clk),
    .rst  (rst),
    .clr  (par_check),
    .load (ld_first),
    .en   (shift_en),
    .d    (sin.x),
    .par  (run_par)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      abort     <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= par_check;
      abort <= abort_nxt;

      // The upper bits of shreg are left stale on a new frame. Every bit is
      // rewritten before the frame can complete.
      if (ld_first) begin
        shreg[0] <= sin.x;
        idx      <= IDX_W'(1);
      end else if (shift_en) begin
        shreg[idx] <= sin.x;
        idx        <= idx + IDX_W'(1);
      end

      if (par_check) begin
        data_out <= shreg;
        err      <= mismatch;
        if (mismatch && (err_count != {CNT_W{1'b1}})) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;
  import parity_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_parity_checker_if sin ();

  // even parity, 8-bit counter
  logic [7:0] e_data;  logic e_done, e_err, e_abort, e_busy; logic [7:0] e_cnt; state_t e_st;
  // odd parity
  logic [7:0] o_data;  logic o_done, o_err, o_abort, o_busy; logic [7:0] o_cnt; state_t o_st;
  // even parity, 2-bit counter
  logic [7:0] s_data;  logic s_done, s_err, s_abort, s_busy; logic [1:0] s_cnt; state_t s_st;

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0), .CNT_W(8)) dut_even (
    .clk(clk), .rst(rst), .sin(sin), .data_out(e_data), .done(e_done), .err(e_err),
    .abort(e_abort), .busy(e_busy), .err_count(e_cnt), .dbg_state(e_st));

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst(rst), .sin(sin), .data_out(o_data), .done(o_done), .err(o_err),
    .abort(o_abort), .busy(o_busy), .err_count(o_cnt), .dbg_state(o_st));

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sin(sin), .data_out(s_data), .done(s_done), .err(s_err),
    .abort(s_abort), .busy(s_busy), .err_count(s_cnt), .dbg_state(s_st));

  int total = 0;
  int bad   = 0;

  // pulse monitors on the even-parity instance
  int done_cnt  = 0;
  int abort_cnt = 0;
  always @(posedge clk) begin
    if (e_done)  done_cnt  <= done_cnt + 1;
    if (e_abort) abort_cnt <= abort_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; sin.x = 1'b0; sin.x_valid = 1'b0; sin.sof = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin.x = b; sin.sof = s; sin.x_valid = 1'b1;
    @(posedge clk);
    #1;
    sin.x_valid = 1'b0; sin.sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == 0);
    send_bit(p, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (e_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", e_data); end
    total++; if ({e_done, e_err, e_abort, e_busy} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", {e_done, e_err, e_abort, e_busy}); end
    total++; if (e_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", e_cnt); end
    total++; if (e_st !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=0", e_st); end
  endtask

  task automatic test_good_frame();
    int d0;
    do_reset();
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i, i == 0);
    total++; if ({e_done, e_busy} !== 2'b01) begin bad++; $display("FAIL good_pre done/busy got=%b want=01", {e_done, e_busy}); end
    send_bit(1'b0, 1'b0);
    total++; if (e_done !== 1'b1) begin bad++; $display("FAIL good_done got=%b want=1", e_done); end
    total++; if (e_data !== 8'hA5) begin bad++; $display("FAIL good_data got=%h want=a5", e_data); end
    total++; if ({e_err, e_busy} !== 2'b00) begin bad++; $display("FAIL good_err/busy got=%b want=00", {e_err, e_busy}); end
    total++; if (e_cnt !== 8'd0) begin bad++; $display("FAIL good_cnt got=%0d want=0", e_cnt); end
    idle(1);
    total++; if (e_done !== 1'b0) begin bad++; $display("FAIL good_done_clr got=%b want=0", e_done); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL good_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_bad_then_good();
    do_reset();
    send_frame(8'hA5, 1'b1);
    total++; if ({e_done, e_err} !== 2'b11) begin bad++; $display("FAIL bad_done/err got=%b want=11", {e_done, e_err}); end
    total++; if (e_cnt !== 8'd1) begin bad++; $display("FAIL bad_cnt got=%0d want=1", e_cnt); end
    idle(2);
    total++; if ({e_done, e_err, e_data} !== {2'b01, 8'hA5}) begin bad++; $display("FAIL bad_hold got=%b/%b/%h want=0/1/a5", e_done, e_err, e_data); end
    send_frame(8'h3C, 1'b0);
    total++; if ({e_done, e_err, e_data} !== {2'b10, 8'h3C}) begin bad++; $display("FAIL good2 got=%b/%b/%h want=1/0/3c", e_done, e_err, e_data); end
    total++; if (e_cnt !== 8'd1) begin bad++; $display("FAIL good2_cnt got=%0d want=1", e_cnt); end
  endtask

  task automatic test_odd();
    do_reset();
    send_frame(8'h01, 1'b0);
    total++; if ({o_done, o_err, o_data} !== {2'b10, 8'h01}) begin bad++; $display("FAIL odd01 got=%b/%b/%h want=1/0/01", o_done, o_err, o_data); end
    total++; if (e_err !== 1'b1) begin bad++; $display("FAIL even01_err got=%b want=1", e_err); end
    send_frame(8'h03, 1'b0);
    total++; if ({o_done, o_err, o_data} !== {2'b11, 8'h03}) begin bad++; $display("FAIL odd03 got=%b/%b/%h want=1/1/03", o_done, o_err, o_data); end
    total++; if (o_cnt !== 8'd1) begin bad++; $display("FAIL odd_cnt got=%0d want=1", o_cnt); end
  endtask

  task automatic test_stall();
    int d0;
    do_reset();
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, i == 0);
      idle(3);
    end
    total++; if ({e_busy, e_st} !== {1'b1, PARITY}) begin bad++; $display("FAIL stall_state got=%b/%0d want=1/2", e_busy, e_st); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL stall_early_done got=%0d want=0", done_cnt - d0); end
    send_bit(1'b0, 1'b0);
    total++; if ({e_done, e_err, e_data} !== {2'b10, 8'hFF}) begin bad++; $display("FAIL stall_result got=%b/%b/%h want=1/0/ff", e_done, e_err, e_data); end
  endtask

  task automatic test_abort();
    int d0, a0;
    logic [7:0] nd;
    do_reset();
    d0 = done_cnt; a0 = abort_cnt; nd = 8'h5A;
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    send_bit(nd[0], 1'b1);
    total++; if ({e_abort, e_busy, e_done} !== 3'b110) begin bad++; $display("FAIL abort_pulse got=%b want=110", {e_abort, e_busy, e_done}); end
    send_bit(nd[1], 1'b0);
    total++; if (e_abort !== 1'b0) begin bad++; $display("FAIL abort_clr got=%b want=0", e_abort); end
    for (int i = 2; i < 8; i++) send_bit(nd[i], 1'b0);
    send_bit(1'b0, 1'b0);
    total++; if ({e_done, e_err, e_data} !== {2'b10, 8'h5A}) begin bad++; $display("FAIL abort_frame got=%b/%b/%h want=1/0/5a", e_done, e_err, e_data); end
    idle(1);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_dones got=%0d want=1", done_cnt - d0); end
    total++; if (abort_cnt - a0 !== 1) begin bad++; $display("FAIL abort_count got=%0d want=1", abort_cnt - a0); end
    total++; if (e_cnt !== 8'd0) begin bad++; $display("FAIL abort_errcnt got=%0d want=0", e_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h3C, 1'b0);
    total++; if ({e_done, e_data} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/3c", e_done, e_data); end
    send_frame(8'hA5, 1'b1);
    total++; if ({e_done, e_err, e_data} !== {2'b11, 8'hA5}) begin bad++; $display("FAIL b2b_second got=%b/%b/%h want=1/1/a5", e_done, e_err, e_data); end
    total++; if (e_cnt !== 8'd1) begin bad++; $display("FAIL b2b_cnt got=%0d want=1", e_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b1);
    total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d want=3", s_cnt); end
    total++; if (e_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt got=%0d want=5", e_cnt); end
    total++; if ({s_done, s_err} !== 2'b11) begin bad++; $display("FAIL sat_flags got=%b want=11", {s_done, s_err}); end
  endtask

  task automatic test_mid_reset();
    int d0;
    do_reset();
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++; if ({e_data, e_done, e_err, e_abort, e_busy} !== 12'h000) begin bad++; $display("FAIL midrst_out got=%h/%b%b%b%b want=00/0000", e_data, e_done, e_err, e_abort, e_busy); end
    total++; if (e_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", e_cnt); end
    send_frame(8'hC3, 1'b0);
    total++; if ({e_done, e_err, e_data} !== {2'b10, 8'hC3}) begin bad++; $display("FAIL midrst_frame got=%b/%b/%h want=1/0/c3", e_done, e_err, e_data); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL midrst_spurious got=%0d want=0", done_cnt - d0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sin.x = 1'b0; sin.x_valid = 1'b0; sin.sof = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_odd();
    test_stall();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule
